// File: rtl/xgen_seq_link.sv
// Sequential transform-matrix generator for one family of revolute links.
// Captures sin/cos and the per-link offset D, forms the two D-dependent
// products over two cycles through one shared fixed-point multiplier, then
// presents 15 registered xform entries under a valid/ready handshake.
module xgen_seq_link #(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16,
    parameter int NUM_LINKS    = 7,
    parameter int LINK_BITS    = 3,
    parameter logic [NUM_LINKS*WIDTH-1:0] D_TABLE = (NUM_LINKS*WIDTH)'(13271) << WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     sinq_in,
    input  logic [WIDTH-1:0]     cosq_in,
    input  logic [LINK_BITS-1:0] link_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 link_err_out,
    output logic [WIDTH-1:0]     xform_out_AX_AX,
    output logic [WIDTH-1:0]     xform_out_AX_AY,
    output logic [WIDTH-1:0]     xform_out_AX_AZ,
    output logic [WIDTH-1:0]     xform_out_AY_AX,
    output logic [WIDTH-1:0]     xform_out_AY_AY,
    output logic [WIDTH-1:0]     xform_out_AY_AZ,
    output logic [WIDTH-1:0]     xform_out_AZ_AY,
    output logic [WIDTH-1:0]     xform_out_AZ_AZ,
    output logic [WIDTH-1:0]     xform_out_LX_AX,
    output logic [WIDTH-1:0]     xform_out_LX_AY,
    output logic [WIDTH-1:0]     xform_out_LX_AZ,
    output logic [WIDTH-1:0]     xform_out_LY_AX,
    output logic [WIDTH-1:0]     xform_out_LY_AY,
    output logic [WIDTH-1:0]     xform_out_LY_AZ,
    output logic [WIDTH-1:0]     xform_out_LZ_AX
);

    localparam int unsigned NL = NUM_LINKS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_C,
        S_MUL_S,
        S_DONE
    } state_t;

    state_t state_q;

    logic signed [WIDTH-1:0]   sin_q;
    logic signed [WIDTH-1:0]   cos_q;
    logic signed [WIDTH-1:0]   d_q;
    logic                      err_q;

    logic signed [WIDTH-1:0]   d_sel;
    logic                      err_sel;
    logic signed [WIDTH-1:0]   mul_a;
    logic signed [WIDTH-1:0]   mul_b;
    logic signed [2*WIDTH-1:0] prod_full;
    logic signed [WIDTH-1:0]   prod_w;
    logic                      accept;

    // Handshake: free when idle, or when the held result is being taken.
    assign ready_out = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_in);
    assign accept    = ready_out && valid_in;

    // Offset lookup; an out-of-table link yields D=0 and flags an error.
    always_comb begin
        d_sel   = '0;
        err_sel = 1'b1;
        for (int unsigned k = 0; k < NL; k++) begin
            if (32'(link_in) == k) begin
                d_sel   = D_TABLE[k*WIDTH +: WIDTH];
                err_sel = 1'b0;
            end
        end
    end

    // Shared multiplier: (-D, cos) in MUL_C, (D, sin) otherwise; floor shift, wrap to WIDTH.
    always_comb begin
        mul_a     = (state_q == S_MUL_C) ? -d_q : d_q;
        mul_b     = (state_q == S_MUL_C) ? cos_q : sin_q;
        prod_full = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
        prod_w    = WIDTH'(prod_full >>> DECIMAL_BITS);
    end

    // Control FSM with operand capture and registered xform outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            sin_q           <= '0;
            cos_q           <= '0;
            d_q             <= '0;
            err_q           <= 1'b0;
            valid_out       <= 1'b0;
            link_err_out    <= 1'b0;
            xform_out_AX_AX <= '0;
            xform_out_AX_AY <= '0;
            xform_out_AX_AZ <= '0;
            xform_out_AY_AX <= '0;
            xform_out_AY_AY <= '0;
            xform_out_AY_AZ <= '0;
            xform_out_AZ_AY <= '0;
            xform_out_AZ_AZ <= '0;
            xform_out_LX_AX <= '0;
            xform_out_LX_AY <= '0;
            xform_out_LX_AZ <= '0;
            xform_out_LY_AX <= '0;
            xform_out_LY_AY <= '0;
            xform_out_LY_AZ <= '0;
            xform_out_LZ_AX <= '0;
        end else begin
            if (accept) begin
                sin_q <= sinq_in;
                cos_q <= cosq_in;
                d_q   <= d_sel;
                err_q <= err_sel;
            end
            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        state_q <= S_MUL_C;
                    end
                end
                S_MUL_C: begin
                    xform_out_LX_AY <= prod_w;
                    state_q         <= S_MUL_S;
                end
                S_MUL_S: begin
                    xform_out_AX_AX <= -cos_q;
                    xform_out_AX_AY <= '0;
                    xform_out_AX_AZ <= sin_q;
                    xform_out_AY_AX <= sin_q;
                    xform_out_AY_AY <= '0;
                    xform_out_AY_AZ <= cos_q;
                    xform_out_AZ_AY <= WIDTH'(1) << DECIMAL_BITS;
                    xform_out_AZ_AZ <= '0;
                    xform_out_LX_AX <= '0;
                    xform_out_LX_AZ <= '0;
                    xform_out_LY_AX <= '0;
                    xform_out_LY_AY <= prod_w;
                    xform_out_LY_AZ <= '0;
                    xform_out_LZ_AX <= -d_q;
                    link_err_out    <= err_q;
                    valid_out       <= 1'b1;
                    state_q         <= S_DONE;
                end
                S_DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        state_q   <= valid_in ? S_MUL_C : S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgen_seq_link.sv
// Self-checking bench for xgen_seq_link: directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// timing/arithmetic model of the request/response behaviour.
module tb_xgen_seq_link;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sinq_in;
    logic [31:0] cosq_in;
    logic [2:0]  link_in;
    logic        valid_in;
    logic        ready_out;
    logic        valid_out;
    logic        ready_in;
    logic        link_err_out;
    logic [31:0] x_ax_ax, x_ax_ay, x_ax_az, x_ay_ax, x_ay_ay, x_ay_az, x_az_ay, x_az_az;
    logic [31:0] x_lx_ax, x_lx_ay, x_lx_az, x_ly_ax, x_ly_ay, x_ly_az, x_lz_ax;
    logic [31:0] dut_x [15];

    int passed = 0;
    int total  = 0;

    // Index order: AX_AX AX_AY AX_AZ AY_AX AY_AY AY_AZ AZ_AY AZ_AZ LX_AX LX_AY LX_AZ LY_AX LY_AY LY_AZ LZ_AX
    string names [15] = '{"AX_AX", "AX_AY", "AX_AZ", "AY_AX", "AY_AY", "AY_AZ", "AZ_AY", "AZ_AZ",
                          "LX_AX", "LX_AY", "LX_AZ", "LY_AX", "LY_AY", "LY_AZ", "LZ_AX"};

    xgen_seq_link dut (
        .clk             (clk),
        .reset           (reset),
        .sinq_in         (sinq_in),
        .cosq_in         (cosq_in),
        .link_in         (link_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .link_err_out    (link_err_out),
        .xform_out_AX_AX (x_ax_ax),
        .xform_out_AX_AY (x_ax_ay),
        .xform_out_AX_AZ (x_ax_az),
        .xform_out_AY_AX (x_ay_ax),
        .xform_out_AY_AY (x_ay_ay),
        .xform_out_AY_AZ (x_ay_az),
        .xform_out_AZ_AY (x_az_ay),
        .xform_out_AZ_AZ (x_az_az),
        .xform_out_LX_AX (x_lx_ax),
        .xform_out_LX_AY (x_lx_ay),
        .xform_out_LX_AZ (x_lx_az),
        .xform_out_LY_AX (x_ly_ax),
        .xform_out_LY_AY (x_ly_ay),
        .xform_out_LY_AZ (x_ly_az),
        .xform_out_LZ_AX (x_lz_ax)
    );

    assign dut_x[0]  = x_ax_ax;
    assign dut_x[1]  = x_ax_ay;
    assign dut_x[2]  = x_ax_az;
    assign dut_x[3]  = x_ay_ax;
    assign dut_x[4]  = x_ay_ay;
    assign dut_x[5]  = x_ay_az;
    assign dut_x[6]  = x_az_ay;
    assign dut_x[7]  = x_az_az;
    assign dut_x[8]  = x_lx_ax;
    assign dut_x[9]  = x_lx_ay;
    assign dut_x[10] = x_lx_az;
    assign dut_x[11] = x_ly_ax;
    assign dut_x[12] = x_ly_ay;
    assign dut_x[13] = x_ly_az;
    assign dut_x[14] = x_lz_ax;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                      nm, $signed(act), act, $signed(exp), exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int prod(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> 16);
    endfunction

    function automatic int d_of(input logic [2:0] lk);
        return (lk == 3'd1) ? 13271 : 0;
    endfunction

    bit m_busy  = 1'b0;   // accepted, result not yet presented
    int m_age   = 0;      // edges since acceptance
    bit m_valid = 1'b0;   // result presented downstream
    int pend_x [15];
    bit pend_err;
    int exp_x [15];
    bit exp_err;

    function automatic bit model_ready();
        return (!m_busy && !m_valid) || (m_valid && ready_in);
    endfunction

    task automatic model_capture();
        int d, s, c;
        d = d_of(link_in);
        s = sinq_in;
        c = cosq_in;
        pend_err = (link_in >= 3'd7);
        foreach (pend_x[i]) pend_x[i] = 0;
        pend_x[0]  = -c;
        pend_x[2]  = s;
        pend_x[3]  = s;
        pend_x[5]  = c;
        pend_x[6]  = 65536;
        pend_x[9]  = prod(-d, c);
        pend_x[12] = prod(d, s);
        pend_x[14] = -d;
    endtask

    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_age   = 0;
        end else begin
            acc = model_ready() && valid_in;
            if (m_valid && ready_in) m_valid = 1'b0;
            if (m_busy) begin
                m_age++;
                if (m_age == 2) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                    exp_x   = pend_x;
                    exp_err = pend_err;
                end
            end
            if (acc) begin
                m_busy = 1'b1;
                m_age  = 0;
                model_capture();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_out", {31'b0, ready_out}, {31'b0, model_ready()});
            chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
            if (m_valid) begin
                chk("link_err_out", {31'b0, link_err_out}, {31'b0, exp_err});
                for (int i = 0; i < 15; i++) chk(names[i], dut_x[i], exp_x[i]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input logic [2:0] lk, input int s, input int c);
        @(negedge clk);
        #1;
        link_in  = lk;
        sinq_in  = s;
        cosq_in  = c;
        valid_in = 1'b1;
        @(negedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int lat;
        lat = 0;
        while (!valid_out && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, 2);
    endtask

    function automatic int pick();
        case ($urandom % 5)
            0: return int'($urandom);
            1: return int'($urandom_range(131072)) - 65536;
            2: return 32'h8000_0000;
            3: return 46341;
            default: return -int'($urandom_range(65536));
        endcase
    endfunction

    initial begin
        int vcnt;
        reset    = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        link_in  = '0;
        sinq_in  = '0;
        cosq_in  = '0;

        // Reset state
        @(negedge clk);
        chk("rst_valid_out", {31'b0, valid_out}, 0);
        chk("rst_link_err", {31'b0, link_err_out}, 0);
        chk("rst_ready_out", {31'b0, ready_out}, 1);
        for (int i = 0; i < 15; i++) chk({"rst_", names[i]}, dut_x[i], 0);
        #1 reset = 1'b0;

        // Identity-like rotation, link 1
        issue(3'd1, 0, 65536);
        wait_valid("t1");
        chk("t1_AX_AX", x_ax_ax, -65536);
        chk("t1_AY_AZ", x_ay_az, 65536);
        chk("t1_LX_AY", x_lx_ay, -13271);
        chk("t1_LY_AY", x_ly_ay, 0);
        chk("t1_LZ_AX", x_lz_ax, -13271);
        chk("t1_AZ_AY", x_az_ay, 65536);
        chk("t1_err", {31'b0, link_err_out}, 0);

        // Floor truncation of both products
        issue(3'd1, 46341, 46341);
        wait_valid("t2");
        chk("t2_LX_AY", x_lx_ay, -9385);
        chk("t2_LY_AY", x_ly_ay, 9384);
        chk("t2_AX_AX", x_ax_ax, -46341);

        // Out-of-table link
        issue(3'd7, 46341, 46341);
        wait_valid("t3");
        chk("t3_err", {31'b0, link_err_out}, 1);
        chk("t3_LX_AY", x_lx_ay, 0);
        chk("t3_LY_AY", x_ly_ay, 0);
        chk("t3_LZ_AX", x_lz_ax, 0);
        chk("t3_AX_AZ", x_ax_az, 46341);

        // Downstream stall for 5 cycles with ignored request pulses
        @(negedge clk);
        #1 ready_in = 1'b0;
        issue(3'd1, 0, 65536);
        wait_valid("t4");
        for (int n = 0; n < 5; n++) begin
            #1;
            valid_in = n[0];
            link_in  = 3'($urandom);
            sinq_in  = $urandom;
            cosq_in  = $urandom;
            @(negedge clk);
            chk("stall_ready_out", {31'b0, ready_out}, 0);
            chk("stall_valid_out", {31'b0, valid_out}, 1);
            chk("stall_err", {31'b0, link_err_out}, 0);
            chk("stall_LX_AY", x_lx_ay, -13271);
            chk("stall_AX_AX", x_ax_ax, -65536);
            chk("stall_LZ_AX", x_lz_ax, -13271);
        end
        #1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        chk("release_valid_out", {31'b0, valid_out}, 0);

        // Reset while in MUL_S discards the request
        issue(3'd1, 46341, 46341);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_valid_out", {31'b0, valid_out}, 0);
        chk("midrst_LX_AY", x_lx_ay, 0);
        chk("midrst_AX_AX", x_ax_ax, 0);
        chk("midrst_AZ_AY", x_az_ay, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        issue(3'd1, 46341, 46341);
        wait_valid("t5");
        chk("t5_LX_AY", x_lx_ay, -9385);
        chk("t5_LY_AY", x_ly_ay, 9384);

        // Back-to-back requests with ready_in held high: one result per 3 cycles
        @(negedge clk);
        @(negedge clk);
        #1;
        valid_in = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 9; n++) begin
            link_in = 3'($urandom_range(2));
            sinq_in = pick();
            cosq_in = pick();
            @(negedge clk);
            if (valid_out) vcnt++;
            #1;
        end
        chk("b2b_results", vcnt, 3);
        valid_in = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            #1;
            valid_in = ($urandom % 3) != 0;
            ready_in = ($urandom % 4) != 0;
            link_in  = 3'($urandom);
            sinq_in  = pick();
            cosq_in  = pick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
